// File: rtl/ifu_fetch_ctl_p.sv
// IFU fetch-pipe controller: drives the BF->F1->F2 fetch address/request stream,
// arbitrates flush / F2-miss / BTB-kill redirects and throttles issue on fetch-buffer credits.
module ifu_fetch_ctl_p #(
    parameter int              AW          = 32,
    parameter int              FETCH_BYTES = 16,
    parameter int              FB_DEPTH    = 4,
    parameter logic [AW-2:0]   RESET_VEC   = '0,
    localparam int             FB_LSB      = $clog2(FETCH_BYTES),
    localparam int             CW          = $clog2(FB_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [AW-2:0] flush_path,
    input  logic          flush_noredir,
    input  logic          halted,
    input  logic          bp_kill_next_f2,
    input  logic [AW-2:0] bp_target_f2,
    input  logic          ic_hit_f2,
    input  logic          mb_empty,
    input  logic [1:0]    fb_consume,
    input  logic          dma_stall,
    input  logic          write_stall,
    input  logic [31:0]   mrac,
    output logic          fetch_req_f1,
    output logic [AW-2:0] fetch_addr_f1,
    output logic          fetch_req_f2,
    output logic [AW-2:0] fetch_addr_f2,
    output logic          uncacheable_f1,
    output logic [CW-1:0] fb_count,
    output logic          pmu_fetch_stall
);

    localparam int              SW      = CW + 2;
    localparam int              BW      = AW - FB_LSB;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FB_DEPTH);
    localparam logic [BW-1:0]   BLK_ONE = {{(BW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        STALL = 2'b10,
        WFM   = 2'b11
    } state_t;

    state_t          state, state_nxt;
    logic            reset_pend;
    logic [AW-2:0]   bf_addr, miss_addr;
    logic            f1_valid, f2_valid;
    logic [AW-2:0]   f1_addr, f2_addr;
    logic [CW-1:0]   count;

    logic            miss_f2, credit_ok, stall_cond, issue, f1_drop, wfm_exit;
    logic [BW-1:0]   blk_nxt;
    logic [AW-2:0]   bf_seq;
    logic signed [SW-1:0] cnt_sum;

    // Saturate the raw credit sum into the counter range; the low clamp absorbs underflow.
    function automatic logic [CW-1:0] clamp_count(input logic signed [SW-1:0] v);
        if (v[SW-1])          return '0;
        else if (|v[SW-2:CW]) return '1;
        else                  return v[CW-1:0];
    endfunction

    assign fetch_req_f2   = f2_valid & ~flush;
    assign miss_f2        = fetch_req_f2 & ~ic_hit_f2;
    assign fetch_req_f1   = f1_valid & ~flush & ~bp_kill_next_f2 & ~miss_f2;
    assign fetch_addr_f1  = f1_addr;
    assign fetch_addr_f2  = f2_addr;
    assign uncacheable_f1 = ~mrac[{f1_addr[AW-2:AW-5], 1'b0}];
    assign fb_count       = count;

    assign credit_ok  = (count < DEPTH_C) | (fb_consume != 2'd0);
    assign stall_cond = ~credit_ok | dma_stall | write_stall | halted;
    assign issue      = (state == FETCH) & ~stall_cond & ~flush & ~miss_f2 & ~bp_kill_next_f2;
    assign f1_drop    = f1_valid & ~fetch_req_f1 & ~flush;
    assign wfm_exit   = (state == WFM) & mb_empty;

    // Next block address: bump the block index, clear the in-block offset, drop the carry.
    assign blk_nxt = bf_addr[AW-2:FB_LSB-1] + BLK_ONE;
    assign bf_seq  = {blk_nxt, {(FB_LSB-1){1'b0}}};

    assign cnt_sum = $signed({2'b00, count})
                   + $signed({{(SW-1){1'b0}}, issue})
                   - $signed({{(SW-2){1'b0}}, fb_consume})
                   - $signed({{(SW-1){1'b0}}, miss_f2})
                   - $signed({{(SW-1){1'b0}}, f1_drop});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        pmu_fetch_stall = (state == STALL) | (state == WFM);
        if (flush) begin
            if (flush_noredir)                 state_nxt = IDLE;
            else if ((state == WFM) && !mb_empty) state_nxt = WFM;
            else                               state_nxt = FETCH;
        end else begin
            case (state)
                IDLE:    if (reset_pend) state_nxt = FETCH;
                FETCH: begin
                    if (miss_f2)         state_nxt = WFM;
                    else if (stall_cond) state_nxt = STALL;
                end
                STALL: begin
                    if (miss_f2)          state_nxt = WFM;
                    else if (!stall_cond) state_nxt = FETCH;
                end
                WFM:     if (mb_empty) state_nxt = FETCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // BF stage: fetch address selection and miss/redirect bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            reset_pend <= 1'b1;
            bf_addr    <= RESET_VEC;
            miss_addr  <= '0;
            count      <= '0;
        end else begin
            if (flush || (state == IDLE)) reset_pend <= 1'b0;

            if (flush)         bf_addr <= flush_path;
            else if (wfm_exit) bf_addr <= miss_addr;
            else if (!miss_f2) begin
                if (bp_kill_next_f2) bf_addr <= bp_target_f2;
                else if (issue)      bf_addr <= bf_seq;
            end

            if (flush && (state == WFM) && !mb_empty) miss_addr <= flush_path;
            else if (miss_f2)                         miss_addr <= f2_addr;

            if (flush) count <= '0;
            else       count <= clamp_count(cnt_sum);
        end
    end

    // F1/F2 stages: request pipe; a reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            f1_valid <= 1'b0;
            f1_addr  <= '0;
            f2_valid <= 1'b0;
            f2_addr  <= '0;
        end else begin
            f1_valid <= issue;
            if (issue) f1_addr <= bf_addr;
            f2_valid <= fetch_req_f1;
            f2_addr  <= f1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!cnt_sum[SW-1]);
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctl_p.sv
// Bench for ifu_fetch_ctl_p: directed scenarios plus randomized traffic against a
// byte-address behavioural model of the fetch pipe.
module tb_ifu_fetch_ctl_p;

    localparam int            AW    = 32;
    localparam int            FB    = 16;
    localparam int            DEPTH = 4;
    localparam int            CW    = 3;
    localparam logic [AW-2:0] RV    = 31'h100;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_WAIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, flush_noredir, halted, bp_kill_next_f2, ic_hit_f2, mb_empty;
    logic          dma_stall, write_stall;
    logic [AW-2:0] flush_path, bp_target_f2;
    logic [1:0]    fb_consume;
    logic [31:0]   mrac;
    logic          fetch_req_f1, fetch_req_f2, uncacheable_f1, pmu_fetch_stall;
    logic [AW-2:0] fetch_addr_f1, fetch_addr_f2;
    logic [CW-1:0] fb_count;

    ifu_fetch_ctl_p #(
        .AW(AW), .FETCH_BYTES(FB), .FB_DEPTH(DEPTH), .RESET_VEC(RV)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_path(flush_path),
        .flush_noredir(flush_noredir), .halted(halted),
        .bp_kill_next_f2(bp_kill_next_f2), .bp_target_f2(bp_target_f2),
        .ic_hit_f2(ic_hit_f2), .mb_empty(mb_empty), .fb_consume(fb_consume),
        .dma_stall(dma_stall), .write_stall(write_stall), .mrac(mrac),
        .fetch_req_f1(fetch_req_f1), .fetch_addr_f1(fetch_addr_f1),
        .fetch_req_f2(fetch_req_f2), .fetch_addr_f2(fetch_addr_f2),
        .uncacheable_f1(uncacheable_f1), .fb_count(fb_count),
        .pmu_fetch_stall(pmu_fetch_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state, addresses kept as byte addresses
    int          m_mode;
    bit          m_rpend, m_f1v, m_f2v, m_known;
    logic [31:0] m_bf, m_miss, m_f1a, m_f2a;
    int          m_cnt;
    logic [31:0] f1_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (f1_log.size() > i) return f1_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: called just after a falling edge with inputs already applied.
    task automatic cyc();
        bit          rq1, rq2, miss, credit, blocked, iss;
        int          n_mode, n_cnt;
        bit          n_rpend;
        logic [31:0] n_bf, n_miss;
        #1;
        rq2     = m_f2v && !flush;
        miss    = rq2 && !ic_hit_f2;
        rq1     = m_f1v && !flush && !bp_kill_next_f2 && !miss;
        credit  = (m_cnt < DEPTH) || (fb_consume != 2'd0);
        blocked = !credit || dma_stall || write_stall || halted;
        iss     = (m_mode == M_RUN) && !blocked && !flush && !miss && !bp_kill_next_f2;
        if (m_known) begin
            chk("req_f1",   32'(fetch_req_f1), 32'(rq1));
            chk("addr_f1",  32'(fetch_addr_f1), m_f1a >> 1);
            chk("req_f2",   32'(fetch_req_f2), 32'(rq2));
            chk("addr_f2",  32'(fetch_addr_f2), m_f2a >> 1);
            chk("unc_f1",   32'(uncacheable_f1), 32'(!mrac[2 * int'(m_f1a[31:28])]));
            chk("fb_count", 32'(fb_count), 32'(m_cnt));
            chk("pmu",      32'(pmu_fetch_stall), 32'((m_mode == M_HOLD) || (m_mode == M_WAIT)));
        end
        if (fetch_req_f1 === 1'b1) f1_log.push_back({1'b0, fetch_addr_f1} << 1);

        n_cnt = m_cnt + int'(iss) - int'(fb_consume) - int'(miss) - int'(m_f1v && !rq1 && !flush);
        if (n_cnt < 0) n_cnt = 0;
        if (flush) n_cnt = 0;

        n_bf = m_bf;
        if (flush)                                n_bf = {1'b0, flush_path} << 1;
        else if ((m_mode == M_WAIT) && mb_empty)  n_bf = m_miss;
        else if (miss)                            n_bf = m_bf;
        else if (bp_kill_next_f2)                 n_bf = {1'b0, bp_target_f2} << 1;
        else if (iss)                             n_bf = (m_bf & ~32'(FB - 1)) + 32'(FB);

        n_miss = m_miss;
        if (flush && (m_mode == M_WAIT) && !mb_empty) n_miss = {1'b0, flush_path} << 1;
        else if (miss)                                n_miss = m_f2a;

        n_mode = m_mode;
        if (flush)                  n_mode = flush_noredir ? M_IDLE :
                                             (((m_mode == M_WAIT) && !mb_empty) ? M_WAIT : M_RUN);
        else if (m_mode == M_IDLE)  begin if (m_rpend) n_mode = M_RUN; end
        else if (m_mode == M_RUN)   begin if (miss) n_mode = M_WAIT; else if (blocked) n_mode = M_HOLD; end
        else if (m_mode == M_HOLD)  begin if (miss) n_mode = M_WAIT; else if (!blocked) n_mode = M_RUN; end
        else if (mb_empty)          n_mode = M_RUN;

        n_rpend = m_rpend;
        if (flush || (m_mode == M_IDLE)) n_rpend = 1'b0;

        @(posedge clk);
        if (rst) begin
            m_mode = M_IDLE; m_rpend = 1'b1; m_bf = {1'b0, RV} << 1; m_miss = '0;
            m_f1v = 1'b0; m_f1a = '0; m_f2v = 1'b0; m_f2a = '0; m_cnt = 0; m_known = 1'b1;
        end else begin
            m_f2v = rq1;  m_f2a = m_f1a;
            m_f1v = iss;  if (iss) m_f1a = m_bf;
            m_mode = n_mode; m_rpend = n_rpend; m_bf = n_bf; m_miss = n_miss; m_cnt = n_cnt;
        end
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        flush = 1'b0; flush_noredir = 1'b0; flush_path = '0; halted = 1'b0;
        bp_kill_next_f2 = 1'b0; bp_target_f2 = '0; ic_hit_f2 = 1'b1; mb_empty = 1'b1;
        fb_consume = 2'd0; dma_stall = 1'b0; write_stall = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        int lim;
        m_known = 1'b0; m_mode = M_IDLE; m_rpend = 1'b0; m_bf = '0; m_miss = '0;
        m_f1v = 1'b0; m_f2v = 1'b0; m_f1a = '0; m_f2a = '0; m_cnt = 0;
        mrac = 32'h5A5A_A5A5;
        rst  = 1'b1;
        quiet_inputs();
        @(negedge clk);

        // Reset release, sequential fetch, full-buffer stall, single-credit resume
        do_reset();
        f1_log.delete();
        chk("rst_req_f1", 32'(fetch_req_f1), 32'd0);
        chk("rst_addr_f1", 32'(fetch_addr_f1), 32'd0);
        chk("rst_count", 32'(fb_count), 32'd0);
        chk("rst_pmu", 32'(pmu_fetch_stall), 32'd0);
        chk("rst_unc", 32'(uncacheable_f1), 32'(!mrac[0]));
        repeat (8) cyc();
        chk("full_nreq", 32'(f1_log.size()), 32'd4);
        chk("seq0", log_at(0), 32'h200);
        chk("seq1", log_at(1), 32'h210);
        chk("seq2", log_at(2), 32'h220);
        chk("seq3", log_at(3), 32'h230);
        chk("full_pmu", 32'(pmu_fetch_stall), 32'd1);
        chk("full_count", 32'(fb_count), 32'd4);
        fb_consume = 2'd1; cyc();
        fb_consume = 2'd0; repeat (4) cyc();
        chk("resume_nreq", 32'(f1_log.size()), 32'd5);
        chk("resume_addr", log_at(4), 32'h240);
        chk("resume_pmu", 32'(pmu_fetch_stall), 32'd1);

        // F2 miss at 0x230 with F1 live, refetch after miss buffer drains
        do_reset();
        f1_log.delete();
        repeat (4) cyc();
        fb_consume = 2'd1; cyc();
        fb_consume = 2'd0; cyc();
        ic_hit_f2 = 1'b0; mb_empty = 1'b0; cyc();
        ic_hit_f2 = 1'b1;
        chk("miss_count", 32'(fb_count), 32'd2);
        chk("miss_pmu", 32'(pmu_fetch_stall), 32'd1);
        repeat (5) cyc();
        chk("miss_noreq", 32'(f1_log.size()), 32'd4);
        mb_empty = 1'b1; repeat (3) cyc();
        chk("refetch_n", 32'(f1_log.size()), 32'd5);
        chk("refetch_addr", log_at(4), 32'h230);

        // Flush while waiting on the miss buffer retargets the pending refetch
        guard = 0;
        while (fetch_req_f2 !== 1'b1 && guard < 20) begin cyc(); guard++; end
        chk("f2_wait", 32'(fetch_req_f2), 32'd1);
        ic_hit_f2 = 1'b0; mb_empty = 1'b0; cyc();
        ic_hit_f2 = 1'b1; cyc(); cyc();
        chk("wfm_pmu", 32'(pmu_fetch_stall), 32'd1);
        flush = 1'b1; flush_path = 31'h400; cyc();
        flush = 1'b0; f1_log.delete(); cyc(); cyc();
        chk("wfm_hold_pmu", 32'(pmu_fetch_stall), 32'd1);
        chk("wfm_hold_cnt", 32'(fb_count), 32'd0);
        mb_empty = 1'b1; repeat (3) cyc();
        chk("wfm_flush_addr", log_at(0), 32'h800);

        // Flush without redirect parks the pipe until a redirecting flush
        flush = 1'b1; flush_noredir = 1'b1; flush_path = 31'h123; cyc();
        flush = 1'b0; flush_noredir = 1'b0; f1_log.delete();
        repeat (5) cyc();
        chk("noredir_nreq", 32'(f1_log.size()), 32'd0);
        chk("noredir_cnt", 32'(fb_count), 32'd0);
        chk("noredir_pmu", 32'(pmu_fetch_stall), 32'd0);
        flush = 1'b1; flush_path = 31'h600; cyc();
        flush = 1'b0; cyc(); cyc();
        chk("redir_addr", log_at(0), 32'hC00);

        // Top-of-space wrap
        flush = 1'b1; flush_path = 31'h7FFF_FFF8; cyc();
        flush = 1'b0; f1_log.delete(); repeat (3) cyc();
        chk("wrap_top", log_at(0), 32'hFFFF_FFF0);
        chk("wrap_zero", log_at(1), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            flush           = ($urandom_range(0, 99) < 3);
            flush_noredir   = ($urandom_range(0, 3) == 0);
            flush_path      = 31'($urandom);
            halted          = ($urandom_range(0, 99) < 4);
            bp_kill_next_f2 = ($urandom_range(0, 99) < 8);
            bp_target_f2    = 31'($urandom);
            ic_hit_f2       = ($urandom_range(0, 99) < 85);
            mb_empty        = ($urandom_range(0, 99) < 35);
            dma_stall       = ($urandom_range(0, 99) < 5);
            write_stall     = ($urandom_range(0, 99) < 5);
            lim = m_cnt - int'(m_f1v) - int'(m_f2v);
            if (lim < 0) lim = 0;
            if (lim > 2) lim = 2;
            fb_consume = 2'($urandom_range(0, lim));
            if ($urandom_range(0, 49) == 0) mrac = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
